csr_trap_ctrl: RTL
==================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1, meaning a SYSTEM-opcode instruction is offered.
REQ-004 SHALL have port req_ready, output, 1, meaning the block accepts the offer this cycle.
REQ-005 SHALL have port req_inst, input, 32, the offered instruction.
REQ-006 SHALL have port req_pc, input, 64, the PC of the offered instruction.
REQ-007 SHALL have port csr_rdata, output, 64, the old value of the latched CSR, fed to the CSR execute unit.
REQ-008 SHALL have port ex_result, input, 64, the new CSR value returned by the CSR execute unit.
REQ-009 SHALL have port rd_we, output, 1, the GPR write enable.
REQ-010 SHALL have port rd_wdata, output, 64, the GPR write data.
REQ-011 SHALL have port redirect_valid, output, 1, a one-cycle PC redirect strobe.
REQ-012 SHALL have port redirect_pc, output, 64, the redirect target.
REQ-013 SHALL have port illegal, output, 1, a one-cycle illegal-instruction strobe.

Function
REQ-014 SHALL implement mstatus (0x300), mtvec (0x305), mepc (0x341) and mcause (0x342). Only mstatus bits MIE[3] and MPIE[7] are writable; other mstatus bits read 0. mepc[1:0] always reads 0.
REQ-015 SHALL use FSM states IDLE, CSR_WB, TRAP_SAVE, TRAP_JUMP and MRET; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request only when req_valid&&req_ready, latching req_inst and req_pc; req_valid in any other state is ignored and held by the requester.
REQ-017 SHALL decode as follows; opcode!=7'b1110011 counts as unsupported:
- funct3 001, 010 or 011 with a supported address -> CSR_WB.
- funct3 000 with inst[31:20]=0x000 -> TRAP_SAVE, cause 11 (ecall).
- funct3 000 with inst[31:20]=0x302 -> MRET.
- anything else -> illegal=1 in the cycle after accept, then TRAP_SAVE with cause 2.
REQ-018 SHALL drive csr_rdata combinationally from the latched CSR address in every state; it is 0 for an unsupported address.
REQ-019 SHALL, in CSR_WB (one cycle after accept), do all of the following, then return to IDLE:
- write ex_result into the CSR, masked per REQ-014;
- suppress that write for csrrs/csrrc when rs1 field inst[19:15]=0;
- drive rd_wdata = old csr_rdata;
- drive rd_we = 1 when rd field inst[11:7]!=0.
REQ-020 SHALL, in TRAP_SAVE, set mepc<=latched pc, mcause<=cause, MPIE<=MIE and MIE<=0, then go to TRAP_JUMP.
REQ-021 SHALL, in TRAP_JUMP, pulse redirect_valid with redirect_pc={mtvec[63:2],2'b00}, then go to IDLE.
REQ-022 SHALL, in MRET, pulse redirect_valid with redirect_pc=mepc, set MIE<=MPIE and MPIE<=1, then go to IDLE.
REQ-023 SHALL give these latencies measured from accept edge N:
- csr op: rd_we at N+1, next accept at N+2.
- ecall/illegal: redirect at N+2, next accept at N+3.
- mret: redirect at N+1.
REQ-024 SHALL keep rd_we, redirect_valid and illegal low outside the states named above; they are never high simultaneously except illegal with nothing else.
REQ-025 SHALL write no CSR and update no CSR field in IDLE.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set state=IDLE, clear all CSRs to 0 and clear all latches.
REQ-027 SHALL hold rd_we=0, redirect_valid=0, illegal=0 and redirect_pc=0 during reset, and hold req_ready=0 while rst=1 (1 after reset).
REQ-028 SHALL abandon any in-flight operation on reset mid-operation: no CSR write, no GPR write, no redirect.

Verification
REQ-029 SHALL pass: csrrw x5, mtvec with ex_result=0x8000_0004 -> rd_we=1 and rd_wdata=0 at N+1, then mtvec reads 0x8000_0004.
REQ-030 SHALL pass: csrrs x0, mstatus with rs1=0 -> rd_we=0 and mstatus unchanged; with ex_result=0xFFFF..FF and rs1!=0 -> mstatus reads 0x88.
REQ-031 SHALL pass: MIE=1, mtvec=0x1003, ecall at pc=0x2000 -> redirect_pc=0x1000 at N+2, mepc=0x2000, mcause=11, mstatus=0x80.
REQ-032 SHALL pass: after REQ-031 state, mret -> redirect_pc=0x2000 at N+1, and mstatus=0x88.
REQ-033 SHALL pass: csrrw to 0x7C0 -> illegal=1 at N+1, mcause=2, redirect to mtvec at N+2.
REQ-034 SHALL pass: rst asserted in TRAP_SAVE -> no redirect_valid, all CSRs 0, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) with ecall, mret and
// illegal-instruction trap sequencing for SYSTEM-opcode instructions.
//
// state     | meaning
// IDLE      | ready, waiting for a SYSTEM instruction
// CSR_WB    | CSR write-back and GPR write of the old CSR value
// TRAP_SAVE | save pc/cause into mepc/mcause, stack MIE into MPIE
// TRAP_JUMP | redirect to mtvec base
// MRET      | redirect to mepc, restore MIE from MPIE
module csr_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_inst,
    input  logic [63:0] req_pc,
    output logic [63:0] csr_rdata,
    input  logic [63:0] ex_result,
    output logic        rd_we,
    output logic [63:0] rd_wdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE, CSR_WB, TRAP_SAVE, TRAP_JUMP, MRET
    } state_e;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] pc_q, pc_d;
    logic        trap_ill_q, trap_ill_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;

    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic        req_sys;
    logic        csr_wr;

    function automatic logic csr_supported(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
    endfunction

    assign req_opcode = req_inst[6:0];
    assign req_funct3 = req_inst[14:12];
    assign req_addr   = req_inst[31:20];
    assign req_sys    = (req_opcode == OPC_SYSTEM);

    always_comb begin
        case (addr_q)
            12'h300: csr_rdata = {56'd0, mpie_q, 3'd0, mie_q, 3'd0};
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = {mepc_q[63:2], 2'b00};
            12'h342: csr_rdata = mcause_q;
            default: csr_rdata = 64'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rs1_d          = rs1_q;
        rd_d           = rd_q;
        funct3_d       = funct3_q;
        pc_d           = pc_q;
        trap_ill_d     = trap_ill_q;
        mie_d          = mie_q;
        mpie_d         = mpie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        req_ready      = 1'b0;
        rd_we          = 1'b0;
        rd_wdata       = 64'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        illegal        = 1'b0;
        csr_wr         = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    rs1_d    = req_inst[19:15];
                    rd_d     = req_inst[11:7];
                    funct3_d = req_funct3;
                    pc_d     = req_pc;
                    if (req_sys && (req_funct3 inside {3'b001, 3'b010, 3'b011})
                        && csr_supported(req_addr)) begin
                        state_d = CSR_WB;
                    end else if (req_sys && req_funct3 == 3'b000 && req_addr == 12'h000) begin
                        trap_ill_d = 1'b0;
                        state_d    = TRAP_SAVE;
                    end else if (req_sys && req_funct3 == 3'b000 && req_addr == 12'h302) begin
                        state_d = MRET;
                    end else begin
                        trap_ill_d = 1'b1;
                        state_d    = TRAP_SAVE;
                    end
                end
            end
            CSR_WB: begin
                rd_we    = (rd_q != 5'd0);
                rd_wdata = csr_rdata;
                // csrrs/csrrc with rs1=x0 are pure reads
                csr_wr   = (funct3_q == 3'b001) || (rs1_q != 5'd0);
                if (csr_wr) begin
                    case (addr_q)
                        12'h300: begin
                            mie_d  = ex_result[3];
                            mpie_d = ex_result[7];
                        end
                        12'h305: mtvec_d  = ex_result;
                        12'h341: mepc_d   = {ex_result[63:2], 2'b00};
                        12'h342: mcause_d = ex_result;
                        default: ;
                    endcase
                end
                state_d = IDLE;
            end
            TRAP_SAVE: begin
                illegal  = trap_ill_q;
                mepc_d   = {pc_q[63:2], 2'b00};
                mcause_d = trap_ill_q ? 64'd2 : 64'd11;
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                state_d  = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mtvec_q[63:2], 2'b00};
                state_d        = IDLE;
            end
            MRET: begin
                redirect_valid = 1'b1;
                redirect_pc    = {mepc_q[63:2], 2'b00};
                mie_d          = mpie_q;
                mpie_d         = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The reset edge discards whatever this cycle computed, so strobes stay quiet too.
        if (rst) begin
            req_ready      = 1'b0;
            rd_we          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 64'd0;
            illegal        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 12'd0;
            rs1_q      <= 5'd0;
            rd_q       <= 5'd0;
            funct3_q   <= 3'd0;
            pc_q       <= 64'd0;
            trap_ill_q <= 1'b0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rs1_q      <= rs1_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            pc_q       <= pc_d;
            trap_ill_q <= trap_ill_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule
